// File: rtl/mem_bus_arbiter_if.sv
// Requester handshakes and shared device port of the memory bus arbiter.
// slave is the arbiter's view; master is the view of the M-stage, loader and bridge.
interface mem_bus_arbiter_if;
    logic        m0_req;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_byteen;
    logic        m0_ack;
    logic [31:0] m0_rdata;
    logic        m0_err;

    logic        m1_req;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_byteen;
    logic        m1_ack;
    logic [31:0] m1_rdata;
    logic        m1_err;

    logic        bus_en;
    logic [1:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_rdata;
    logic        busy;

    modport slave (
        input  m0_req, m0_addr, m0_wdata, m0_byteen,
        output m0_ack, m0_rdata, m0_err,
        input  m1_req, m1_addr, m1_wdata, m1_byteen,
        output m1_ack, m1_rdata, m1_err,
        output bus_en, bus_sel, bus_addr, bus_wdata, bus_byteen,
        input  bus_rdata,
        output busy
    );

    modport master (
        output m0_req, m0_addr, m0_wdata, m0_byteen,
        input  m0_ack, m0_rdata, m0_err,
        output m1_req, m1_addr, m1_wdata, m1_byteen,
        input  m1_ack, m1_rdata, m1_err,
        input  bus_en, bus_sel, bus_addr, bus_wdata, bus_byteen,
        output bus_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the DM/TC1/TC2 port between the CPU M-stage
// and the loader, with a fixed wait-state window and device decode.
module mem_bus_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] DM_BEGIN    = 32'h0000_0000,
    parameter logic [31:0] DM_END      = 32'h0000_2FFF,
    parameter logic [31:0] TC1_BEGIN   = 32'h0000_7F00,
    parameter logic [31:0] TC2_BEGIN   = 32'h0000_7F10
) (
    input  logic               clk,
    input  logic               reset,
    mem_bus_arbiter_if.slave   mbus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP,
        ERR
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        rr_last_q, rr_last_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  byteen_q, byteen_d;
    logic [1:0]  sel_q, sel_d;
    logic [31:0] rdata_q, rdata_d;

    logic        pick;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_byteen;
    logic [31:0] off1;
    logic [31:0] off2;
    logic [3:0]  tc_off;
    logic [1:0]  dec_sel;
    logic        dec_bad;

    // Contended grant goes to the master that was not served last.
    assign pick = (mbus.m0_req && mbus.m1_req) ? ~rr_last_q : ~mbus.m0_req;

    assign req_addr   = pick ? mbus.m1_addr   : mbus.m0_addr;
    assign req_wdata  = pick ? mbus.m1_wdata  : mbus.m0_wdata;
    assign req_byteen = pick ? mbus.m1_byteen : mbus.m0_byteen;

    assign off1 = req_addr - TC1_BEGIN;
    assign off2 = req_addr - TC2_BEGIN;

    always_comb begin
        dec_sel = 2'b00;
        dec_bad = 1'b0;
        tc_off  = 4'h0;
        if ((req_addr - DM_BEGIN) <= (DM_END - DM_BEGIN)) begin
            dec_sel = 2'b01;
        end else if (off1 < 32'd12) begin
            dec_sel = 2'b10;
            tc_off  = off1[3:0];
        end else if (off2 < 32'd12) begin
            dec_sel = 2'b11;
            tc_off  = off2[3:0];
        end else begin
            dec_bad = 1'b1;
        end
        // Timer writes must be full-word and may not touch the count register.
        if (dec_sel[1] && (req_byteen != 4'h0) &&
            ((req_byteen != 4'hF) || (tc_off >= 4'h8))) begin
            dec_bad = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        byteen_d  = byteen_q;
        sel_d     = sel_q;
        rdata_d   = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (mbus.m0_req || mbus.m1_req) begin
                    owner_d  = pick;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    byteen_d = req_byteen;
                    sel_d    = dec_sel;
                    if (dec_bad) begin
                        state_d = ERR;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            ACCESS: begin
                if (cnt_q != 4'h0) begin
                    cnt_d = cnt_q - 4'h1;
                end else begin
                    rdata_d = mbus.bus_rdata;
                    state_d = RESP;
                end
            end
            RESP, ERR: begin
                rr_last_d = owner_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'h0;
            owner_q   <= 1'b0;
            rr_last_q <= 1'b1;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            byteen_q  <= 4'h0;
            sel_q     <= 2'b00;
            rdata_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            byteen_q  <= byteen_d;
            sel_q     <= sel_d;
            rdata_q   <= rdata_d;
        end
    end

    logic        ack;
    logic        rd_ok;
    logic        active;
    logic [31:0] rsp_data;

    assign ack      = (state_q == RESP) || (state_q == ERR);
    assign rd_ok    = (state_q == RESP) && (byteen_q == 4'h0);
    assign active   = (state_q != IDLE);
    assign rsp_data = rd_ok ? rdata_q : 32'h0;

    assign mbus.m0_ack   = ack && !owner_q;
    assign mbus.m1_ack   = ack && owner_q;
    assign mbus.m0_err   = (state_q == ERR) && !owner_q;
    assign mbus.m1_err   = (state_q == ERR) && owner_q;
    assign mbus.m0_rdata = owner_q ? 32'h0 : rsp_data;
    assign mbus.m1_rdata = owner_q ? rsp_data : 32'h0;

    assign mbus.bus_en     = (state_q == ACCESS);
    assign mbus.bus_sel    = (state_q == ACCESS) ? sel_q : 2'b00;
    assign mbus.bus_addr   = active ? addr_q : 32'h0;
    assign mbus.bus_wdata  = active ? wdata_q : 32'h0;
    assign mbus.bus_byteen = active ? byteen_q : 4'h0;
    assign mbus.busy       = active;

endmodule
